seg7_scan_counter: RTL and testbench
====================================

SEG7_SCAN_COUNTER -- requirements
Module: seg7_scan_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits and display positions, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit-scan step, minimum 2.
REQ-003 Parameter STEP_DIV, default 25000000: clk cycles per count step, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 en  input  1  count enable, sampled on count-tick cycles only.
REQ-007 up_dn  input  1  direction: 1 counts up, 0 counts down.
REQ-008 load  input  1  synchronous parallel load request.
REQ-009 load_val  input  4*DIGITS  BCD load value; nibble 0 is the least significant digit.
REQ-010 count  output  4*DIGITS  registered BCD counter value.
REQ-011 carry  output  1  one-cycle pulse on wrap-around in either direction.
REQ-012 digit_sel  output  DIGITS  active-low one-hot anode select; bit 0 is the least significant digit.
REQ-013 seg_n  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.

Function
REQ-014 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be high for the one cycle in which the prescaler equals SCAN_DIV-1.
REQ-015 Step prescaler SHALL behave the same way with STEP_DIV, producing step_tick; the two prescalers SHALL run independently of each other and free of en.
REQ-016 load SHALL take priority over counting: when load=1, count SHALL equal load_val on the next cycle, regardless of whether step_tick or en is high.
REQ-017 Any load_val nibble greater than 9 SHALL load 0 into that digit; the other nibbles SHALL load unchanged.
REQ-018 When load=0, step_tick=1 and en=1, count SHALL step by one in BCD in the direction given by up_dn on the next cycle; otherwise count SHALL hold.
REQ-019 Counting up from all 9s SHALL wrap to all 0s, and counting down from all 0s SHALL wrap to all 9s; carry SHALL be 1 in the cycle in which the wrapped value first appears, and 0 otherwise.
REQ-020 A load SHALL never assert carry.
REQ-021 Scan index SHALL advance by one on each scan_tick and wrap from DIGITS-1 to 0.
REQ-022 digit_sel and seg_n SHALL be registered from the same index value and update on the same edge, one cycle after that index value.
REQ-023 digit_sel SHALL drive bit[index] low and all other bits high, so that exactly one bit is low at all times.
REQ-024 seg_n SHALL decode the selected digit as follows, written {g..a} active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-025 seg_n SHALL reflect the count value registered at the time of decode; a count change SHALL be visible on the displayed digit within one cycle.

Reset
REQ-026 While rst=1, the following SHALL hold on the next edge, with rst taking priority over load and en:
- count = 0, carry = 0, both prescalers = 0, index = 0
- digit_sel = all 1s except bit 0 = 0
- seg_n = 1000000
REQ-027 An rst asserted in the middle of a scan period or count period SHALL discard the partial period; the first scan_tick after rst is released SHALL occur SCAN_DIV cycles after release, and the first step_tick STEP_DIV cycles after release.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN: when it is defined, a digit at position k>0 whose value and all higher-position digit values are 0 SHALL drive seg_n = 1111111; digit 0 SHALL never be blanked; digit_sel scanning SHALL be unchanged.
REQ-029 When SEG7_LEADING_ZERO_BLANK_EN is undefined, every digit SHALL be decoded per REQ-024, and no blanking logic SHALL be synthesised.

Verification (DIGITS=4, SCAN_DIV=4, STEP_DIV=8)
REQ-030 Reset, then en=1, up_dn=1 for 80 cycles -> count=0x0010, and count changes exactly every 8 cycles.
REQ-031 Load 0x9999, then en=1, up_dn=1 -> after the next step, count=0x0000 with carry high for exactly one cycle.
REQ-032 Load 0x0000, then up_dn=0 -> after one step, count=0x9999 with a one-cycle carry; load 0x12A4 -> count=0x1204.
REQ-033 Load 0x5678 with en=0 and observe 16 cycles -> digit_sel sequence 1110, 1101, 1011, 0111 at 4-cycle spacing, with seg_n 0000000, 1111000, 0000010, 0010010 in the same order.
REQ-034 Load 0x0007 with the macro defined -> digits 3..1 show 1111111 and digit 0 shows 1111000; without the macro, digits 3..1 show 1000000.
REQ-035 Assert rst for 1 cycle in the middle of counting from 0x0042 -> next cycle count=0x0000, digit_sel=1110, seg_n=1000000, and the first count step occurs 8 cycles after rst is released.

Source files
------------

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down counter with multiplexed active-low 7-segment scan output.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int STEP_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg_n
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [SCAN_W-1:0]   scan_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                scan_tick;
    logic                step_tick;
    logic [IDX_W-1:0]    idx;

    logic [4*DIGITS-1:0] load_bcd;
    logic [4*DIGITS-1:0] step_bcd;
    logic                ripple;
    logic [3:0]          cur_digit;
    logic [3:0]          sel_digit;
    logic [6:0]          seg_dec;
    logic [6:0]          seg_next;

    assign scan_tick = (scan_cnt == SCAN_LAST);
    assign step_tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            step_cnt <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
        end
    end

    // Ripple survives past the top digit only when every digit wrapped (all 9s up / all 0s down).
    always_comb begin
        load_bcd  = '0;
        step_bcd  = '0;
        ripple    = 1'b1;
        cur_digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
            cur_digit = count[4*i +: 4];
            if (!ripple) begin
                step_bcd[4*i +: 4] = cur_digit;
            end else if (up_dn) begin
                if (cur_digit == 4'd9) begin
                    step_bcd[4*i +: 4] = 4'd0;
                end else begin
                    step_bcd[4*i +: 4] = cur_digit + 4'd1;
                    ripple = 1'b0;
                end
            end else begin
                if (cur_digit == 4'd0) begin
                    step_bcd[4*i +: 4] = 4'd9;
                end else begin
                    step_bcd[4*i +: 4] = cur_digit - 4'd1;
                    ripple = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            carry <= 1'b0;
        end else if (load) begin
            count <= load_bcd;
            carry <= 1'b0;
        end else if (step_tick && en) begin
            count <= step_bcd;
            carry <= ripple;
        end else begin
            carry <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (scan_tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    assign sel_digit = count[4*idx +: 4];

    always_comb begin
        case (sel_digit)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              hi_zero;

    // blank[k] is set when digit k and every digit above it are zero; digit 0 always shows.
    always_comb begin
        hi_zero = 1'b1;
        blank   = '0;
        for (int unsigned k = DIGITS; k > 0; k--) begin
            hi_zero    = hi_zero && (count[4*(k-1) +: 4] == 4'd0);
            blank[k-1] = hi_zero;
        end
        blank[0] = 1'b0;
    end

    assign seg_next = blank[idx] ? 7'b1111111 : seg_dec;
`else
    assign seg_next = seg_dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg_n     <= 7'b1000000;
        end else begin
            digit_sel <= ~(DIGITS'(1) << idx);
            seg_n     <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench for seg7_scan_counter (DIGITS=4, SCAN_DIV=4, STEP_DIV=8).
// The reference model tracks the count as a decimal integer and derives ticks from elapsed cycles.
module tb_seg7_scan_counter;

    localparam int D   = 4;
    localparam int SD  = 4;
    localparam int TD  = 8;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_n;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seg7_scan_counter #(
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .STEP_DIV (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .carry     (carry),
        .digit_sel (digit_sel),
        .seg_n     (seg_n)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int unsigned m_val;
    int unsigned m_n;
    int unsigned m_idx;
    logic        m_carry;
    logic [3:0]  m_sel;
    logic [6:0]  m_seg;

    function automatic int unsigned pow10(int unsigned k);
        int unsigned p = 1;
        for (int unsigned i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(int unsigned v, int unsigned k);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k > 0 && v < pow10(k)) return 7'b1111111;
`endif
        return seg_tab[(v / pow10(k)) % 10];
    endfunction

    function automatic logic [15:0] to_bcd(int unsigned v);
        logic [15:0] r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned from_load(logic [15:0] lv);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lv[4*i +: 4] <= 4'd9) r = r + int'(lv[4*i +: 4]) * pow10(i);
        end
        return r;
    endfunction

    // Reference model: advances once per rising edge from the inputs applied before it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_val = 0; m_n = 0; m_carry = 1'b0;
                m_sel = 4'b1110; m_seg = 7'b1000000;
            end else begin
                m_idx   = (m_n / SD) % D;
                m_sel   = ~(4'b0001 << m_idx);
                m_seg   = exp_seg(m_val, m_idx);
                m_carry = 1'b0;
                if (load) begin
                    m_val = from_load(load_val);
                end else if (en && (m_n % TD) == TD - 1) begin
                    if (up_dn) begin
                        m_val   = (m_val + 1) % MOD;
                        m_carry = (m_val == 0);
                    end else begin
                        m_carry = (m_val == 0);
                        m_val   = (m_val + MOD - 1) % MOD;
                    end
                end
                m_n++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 16'h1234;
        repeat (2) @(negedge clk);
        compared++;
        if (count !== 16'h0000) begin mismatched++; $display("FAIL reset_count: got %h want 0000", count); end
        compared++;
        if (carry !== 1'b0) begin mismatched++; $display("FAIL reset_carry: got %b want 0", carry); end
        compared++;
        if (digit_sel !== 4'b1110) begin mismatched++; $display("FAIL reset_sel: got %b want 1110", digit_sel); end
        compared++;
        if (seg_n !== 7'b1000000) begin mismatched++; $display("FAIL reset_seg: got %b want 1000000", seg_n); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up();
        logic [15:0] prev;
        int changes = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        prev = count;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            compared++;
            if (count !== to_bcd(m_val)) begin mismatched++; $display("FAIL up_count: cyc %0d got %h want %h", c, count, to_bcd(m_val)); end
            if (count !== prev) begin
                changes++;
                compared++;
                if (c % TD != 0) begin mismatched++; $display("FAIL up_spacing: change at cyc %0d want multiple of %0d", c, TD); end
                prev = count;
            end
        end
        compared++;
        if (count !== 16'h0010) begin mismatched++; $display("FAIL up_final: got %h want 0010", count); end
        compared++;
        if (changes != 10) begin mismatched++; $display("FAIL up_changes: got %0d want 10", changes); end
    endtask

    task automatic test_wrap_up();
        bit seen = 0;
        load = 1'b1; load_val = 16'h9999; en = 1'b0; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0;
        compared++;
        if (count !== 16'h9999) begin mismatched++; $display("FAIL wrapup_load: got %h want 9999", count); end
        en = 1'b1;
        for (int c = 0; c < 3 * TD && !seen; c++) begin
            @(negedge clk);
            if (count !== 16'h9999) begin
                seen = 1;
                compared++;
                if (count !== 16'h0000) begin mismatched++; $display("FAIL wrapup_count: got %h want 0000", count); end
                compared++;
                if (carry !== 1'b1) begin mismatched++; $display("FAIL wrapup_carry: got %b want 1", carry); end
                @(negedge clk);
                compared++;
                if (carry !== 1'b0) begin mismatched++; $display("FAIL wrapup_carry_len: got %b want 0", carry); end
            end else begin
                compared++;
                if (carry !== 1'b0) begin mismatched++; $display("FAIL wrapup_early_carry: got %b want 0", carry); end
            end
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL wrapup_timeout: got no step want step within %0d cycles", 3 * TD); end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        bit seen = 0;
        load = 1'b1; load_val = 16'h0000; en = 1'b0; up_dn = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        for (int c = 0; c < 3 * TD && !seen; c++) begin
            @(negedge clk);
            if (count !== 16'h0000) begin
                seen = 1;
                compared++;
                if (count !== 16'h9999) begin mismatched++; $display("FAIL wrapdn_count: got %h want 9999", count); end
                compared++;
                if (carry !== 1'b1) begin mismatched++; $display("FAIL wrapdn_carry: got %b want 1", carry); end
                @(negedge clk);
                compared++;
                if (carry !== 1'b0) begin mismatched++; $display("FAIL wrapdn_carry_len: got %b want 0", carry); end
            end
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL wrapdn_timeout: got no step want step within %0d cycles", 3 * TD); end
        load = 1'b1; load_val = 16'h12A4;
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        compared++;
        if (count !== 16'h1204) begin mismatched++; $display("FAIL load_sanitize: got %h want 1204", count); end
        compared++;
        if (carry !== 1'b0) begin mismatched++; $display("FAIL load_carry: got %b want 0", carry); end
    endtask

    task automatic test_scan();
        logic [3:0] seen = '0;
        logic [6:0] want;
        load = 1'b1; load_val = 16'h5678; en = 1'b0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (digit_sel)
                4'b1110: want = 7'b0000000;
                4'b1101: want = 7'b1111000;
                4'b1011: want = 7'b0000010;
                4'b0111: want = 7'b0010010;
                default: want = 7'bxxxxxxx;
            endcase
            seen = seen | ~digit_sel;
            compared++;
            if (digit_sel !== m_sel) begin mismatched++; $display("FAIL scan_sel: cyc %0d got %b want %b", c, digit_sel, m_sel); end
            compared++;
            if (seg_n !== want) begin mismatched++; $display("FAIL scan_seg: sel %b got %b want %b", digit_sel, seg_n, want); end
        end
        compared++;
        if (seen !== 4'b1111) begin mismatched++; $display("FAIL scan_cover: got %b want 1111", seen); end
    endtask

    task automatic test_blank();
        logic [6:0] want;
        load = 1'b1; load_val = 16'h0007; en = 1'b0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            want = (digit_sel == 4'b1110) ? 7'b1111000 : 7'b1111111;
`else
            want = (digit_sel == 4'b1110) ? 7'b1111000 : 7'b1000000;
`endif
            compared++;
            if (seg_n !== want) begin mismatched++; $display("FAIL blank_seg: sel %b got %b want %b", digit_sel, seg_n, want); end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        load = 1'b1; load_val = 16'h0042; en = 1'b0; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (count !== 16'h0000) begin mismatched++; $display("FAIL rstmid_count: got %h want 0000", count); end
        compared++;
        if (digit_sel !== 4'b1110) begin mismatched++; $display("FAIL rstmid_sel: got %b want 1110", digit_sel); end
        compared++;
        if (seg_n !== 7'b1000000) begin mismatched++; $display("FAIL rstmid_seg: got %b want 1000000", seg_n); end
        for (int c = 1; c <= 12 && first < 0; c++) begin
            @(negedge clk);
            if (count !== 16'h0000) first = c;
        end
        compared++;
        if (first != TD) begin mismatched++; $display("FAIL rstmid_first_step: got cyc %0d want %0d", first, TD); end
        compared++;
        if (count !== 16'h0001) begin mismatched++; $display("FAIL rstmid_step_val: got %h want 0001", count); end
        en = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] picks [4] = '{16'h9999, 16'h0000, 16'h9998, 16'h0001};
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom % 150) == 0;
            load  = ($urandom % 12) == 0;
            en    = ($urandom % 4) != 0;
            if ($urandom % 32 == 0) up_dn = ~up_dn;
            load_val = ($urandom % 2) ? 16'($urandom) : picks[$urandom % 4];
            @(negedge clk);
            compared++;
            if (count !== to_bcd(m_val)) begin mismatched++; $display("FAIL rnd_count: cyc %0d got %h want %h", c, count, to_bcd(m_val)); end
            compared++;
            if (carry !== m_carry) begin mismatched++; $display("FAIL rnd_carry: cyc %0d got %b want %b", c, carry, m_carry); end
            compared++;
            if (digit_sel !== m_sel) begin mismatched++; $display("FAIL rnd_sel: cyc %0d got %b want %b", c, digit_sel, m_sel); end
            compared++;
            if (seg_n !== m_seg) begin mismatched++; $display("FAIL rnd_seg: cyc %0d got %b want %b", c, seg_n, m_seg); end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        @(negedge clk);
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_scan();
        test_blank();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1000000 time units");
        $fatal(1);
    end

endmodule
